// File: rtl/io_bus_pkg.sv
// Shared definitions for the initiator side of the tristate I/O bus:
// bus widths, control encodings and the master's state encoding.
package io_bus_pkg;

    localparam int   CPU_WIDTH     = 16;
    localparam logic IO_CTRL_READ  = 1'b0;
    localparam logic IO_CTRL_WRITE = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RD   = 2'd2,
        ST_TURN = 2'd3
    } bus_state_e;

endpackage

// File: rtl/io_bus_master.sv
// Initiator for the shared tristate I/O bus: takes one CPU request at a time,
// runs the EN/ctrl/data bus cycle and returns a one-cycle completion strobe.
module io_bus_master
    import io_bus_pkg::*;
#(
    parameter int ADDR_W       = CPU_WIDTH,
    parameter int DATA_W       = CPU_WIDTH,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              bus_en,
    output logic              bus_ctrl,
    output logic [ADDR_W-1:0] bus_addr,
    inout  wire  [DATA_W-1:0] bus_data
);

    // RD lasts READ_LATENCY+1 cycles; the counter value on the last one.
    localparam logic [3:0] LAST_CNT = 4'(READ_LATENCY);

    bus_state_e        state;
    bus_state_e        state_next;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [3:0]        cnt;
    logic              wr_done_q;
    logic              drive_en;
    logic              accept;

    assign accept = req_valid && req_ready;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: each combinational output gets a default first, so no path
    // through the case can leave it unassigned and infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (accept) state_next = req_write ? ST_WR : ST_RD;
            ST_WR:   state_next = ST_IDLE;
            ST_RD:   if (cnt == LAST_CNT) state_next = ST_TURN;
            ST_TURN: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready  = 1'b0;
        bus_en     = 1'b0;
        bus_ctrl   = IO_CTRL_READ;
        drive_en   = 1'b0;
        resp_valid = wr_done_q;
        case (state)
            ST_IDLE: req_ready = 1'b1;
            ST_WR: begin
                bus_en   = 1'b1;
                bus_ctrl = IO_CTRL_WRITE;
                drive_en = 1'b1;
            end
            ST_RD:   bus_en = 1'b1;
            ST_TURN: resp_valid = 1'b1;
            default: ;
        endcase
    end

    // Request fields are captured only at acceptance; the bus sees latched copies.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            cnt        <= '0;
            resp_rdata <= '0;
            wr_done_q  <= 1'b0;
        end else begin
            wr_done_q <= (state == ST_WR);
            if (accept) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                cnt     <= '0;
            end else if (state == ST_RD) begin
                cnt <= cnt + 4'd1;
            end
            if (state == ST_RD && cnt == LAST_CNT) begin
                resp_rdata <= bus_data;
            end
        end
    end

    assign bus_addr = addr_q;
    assign bus_data = drive_en ? wdata_q : 'z;

endmodule

// File: tb/tb_io_bus_master.sv
// Bench for io_bus_master: one RAM slave on a pulled-up bus (L=1) checked
// every cycle against a transaction-level model, plus a second L=3 instance.
module tb_io_bus_master;
    import io_bus_pkg::*;

    localparam int L  = 1;
    localparam int LB = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [15:0] req_addr  = '0;
    logic [15:0] req_wdata = '0;
    logic        resp_valid;
    logic [15:0] resp_rdata;
    logic        bus_en;
    logic        bus_ctrl;
    logic [15:0] bus_addr;
    wire  [15:0] bus_data;

    logic        b_req_valid = 1'b0;
    logic        b_req_ready;
    logic        b_req_write = 1'b0;
    logic [15:0] b_req_addr  = 16'h0040;
    logic [15:0] b_req_wdata = 16'h0000;
    logic        b_resp_valid;
    logic [15:0] b_resp_rdata;
    logic        b_bus_en;
    logic        b_bus_ctrl;
    logic [15:0] b_bus_addr;
    wire  [15:0] b_bus_data;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_on   = 1'b0;

    always #5 clk = ~clk;

    io_bus_master #(.ADDR_W(16), .DATA_W(16), .READ_LATENCY(L)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .bus_en(bus_en),
        .bus_ctrl(bus_ctrl), .bus_addr(bus_addr), .bus_data(bus_data)
    );

    io_bus_master #(.ADDR_W(16), .DATA_W(16), .READ_LATENCY(LB)) dut_l3 (
        .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_write(b_req_write), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .resp_valid(b_resp_valid), .resp_rdata(b_resp_rdata), .bus_en(b_bus_en),
        .bus_ctrl(b_bus_ctrl), .bus_addr(b_bus_addr), .bus_data(b_bus_data)
    );

    // Released bus floats high, so an undriven bus reads 0xFFFF.
    for (genvar i = 0; i < 16; i++) begin : g_pu
        pullup (bus_data[i]);
    end

    function automatic logic [15:0] pre(input logic [7:0] a);
        return {a, ~a};
    endfunction

    // RAM slave: commits on the closing edge of a write cycle; read data is
    // only valid after L enable cycles (0xDEAD before that).
    logic [15:0] ram [256];
    bit          ram_ok [256];
    int          s_cnt = 0;
    always @(posedge clk) begin
        if (bus_en && bus_ctrl == IO_CTRL_WRITE) begin
            ram[bus_addr[7:0]]    <= bus_data;
            ram_ok[bus_addr[7:0]] <= 1'b1;
        end
        s_cnt <= (bus_en && bus_ctrl == IO_CTRL_READ) ? s_cnt + 1 : 0;
    end
    assign bus_data = (bus_en && bus_ctrl == IO_CTRL_READ) ?
                      ((s_cnt >= L) ? (ram_ok[bus_addr[7:0]] ? ram[bus_addr[7:0]] : pre(bus_addr[7:0]))
                                    : 16'hDEAD) : 'z;

    int b_cnt = 0;
    always @(posedge clk) b_cnt <= (b_bus_en && b_bus_ctrl == IO_CTRL_READ) ? b_cnt + 1 : 0;
    assign b_bus_data = (b_bus_en && b_bus_ctrl == IO_CTRL_READ) ?
                        ((b_cnt >= LB) ? 16'h1234 : 16'hDEAD) : 'z;

    // Transaction model: cycle c is the cycle whose closing edge is edge c.
    int          cyc     = 0;
    int          t_acc   = -100;
    int          free_at = 0;
    int          acc_cnt = 0;
    logic        op_wr   = 1'b0;
    logic [15:0] op_wdata  = '0;
    logic [15:0] exp_addr  = '0;
    logic [15:0] exp_rdata = '0;
    logic [15:0] sb_mem [256];
    bit          sb_ok  [256];

    function automatic logic [15:0] sb_rd(input logic [7:0] a);
        return sb_ok[a] ? sb_mem[a] : pre(a);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            t_acc     <= -100;
            free_at   <= 0;
            op_wr     <= 1'b0;
            exp_addr  <= '0;
            exp_rdata <= '0;
        end else begin
            cyc <= cyc + 1;
            if (req_valid && cyc >= free_at) begin
                t_acc    <= cyc;
                op_wr    <= req_write;
                op_wdata <= req_wdata;
                exp_addr <= req_addr;
                acc_cnt  <= acc_cnt + 1;
                free_at  <= req_write ? cyc + 2 : cyc + 3 + L;
                if (req_write) begin
                    sb_mem[req_addr[7:0]] <= req_wdata;
                    sb_ok[req_addr[7:0]]  <= 1'b1;
                end
            end
            if (!op_wr && cyc == t_acc + 1 + L) exp_rdata <= sb_rd(exp_addr[7:0]);
        end
    end

    function automatic int dd();
        return cyc - t_acc;
    endfunction
    function automatic logic e_wr();
        return op_wr && dd() == 1;
    endfunction
    function automatic logic e_en();
        return op_wr ? (dd() == 1) : (dd() >= 1 && dd() <= 1 + L);
    endfunction
    function automatic logic e_resp();
        return op_wr ? (dd() == 2) : (dd() == 2 + L);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check("m_ready", req_ready, cyc >= free_at);
            check("m_resp_valid", resp_valid, e_resp());
            check("m_resp_rdata", resp_rdata, exp_rdata);
            check("m_bus_en", bus_en, e_en());
            check("m_bus_ctrl", bus_ctrl, e_wr() ? IO_CTRL_WRITE : IO_CTRL_READ);
            check("m_bus_addr", bus_addr, exp_addr);
            if (e_wr())
                check("m_bus_data_wr", bus_data, op_wdata);
            else if (!e_en())
                check("m_bus_data_released", bus_data, 16'hFFFF);
            else if (dd() == 1 + L)
                check("m_bus_data_rd", bus_data, sb_rd(exp_addr[7:0]));
        end
    end

    // Present a request (req_valid stays high) and return just after acceptance.
    task automatic issue(input logic wr, input logic [15:0] a, input logic [15:0] wd);
        int start;
        start = acc_cnt;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = wd;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (acc_cnt != start) break;
        end
        check("accept_seen", acc_cnt - start, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout at t=%0t", $time);
        $fatal(1);
    end

    initial begin
        chk_on = 1'b1;
        @(negedge clk);
        check("rst_ready", req_ready, 1);
        check("rst_bus_en", bus_en, 0);
        check("rst_resp_rdata", resp_rdata, 16'h0000);
        check("rst_bus_data", bus_data, 16'hFFFF);
        @(negedge clk);
        rst = 1'b0;

        // Write 0x0010 <- 0xBEEF, then read it back.
        issue(1'b1, 16'h0010, 16'hBEEF);
        @(negedge clk); req_valid = 1'b0;
        check("wr_en_t1", bus_en, 1);
        check("wr_ctrl_t1", bus_ctrl, IO_CTRL_WRITE);
        check("wr_data_t1", bus_data, 16'hBEEF);
        @(negedge clk);
        check("wr_en_t2", bus_en, 0);
        check("wr_resp_t2", resp_valid, 1);
        check("wr_ready_t2", req_ready, 1);
        issue(1'b0, 16'h0010, 16'h0000);
        @(negedge clk); req_valid = 1'b0;
        check("rd_en_t1", bus_en, 1);
        @(negedge clk);
        check("rd_en_t2", bus_en, 1);
        @(negedge clk);
        check("rd_turn_en", bus_en, 0);
        check("rd_resp_t3", resp_valid, 1);
        check("rd_data_t3", resp_rdata, 16'hBEEF);
        check("rd_ready_turn", req_ready, 0);

        // Write 0x00FF <- 0xFFFF; previous read data must hold across it.
        issue(1'b1, 16'h00FF, 16'hFFFF);
        @(negedge clk); req_valid = 1'b0;
        check("hold_rdata_wr", resp_rdata, 16'hBEEF);
        @(negedge clk);
        check("hold_rdata_resp", resp_rdata, 16'hBEEF);
        issue(1'b0, 16'h00FF, 16'h0000);
        @(negedge clk); req_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("rd_ffff", resp_rdata, 16'hFFFF);

        // Read/write alternation on 0x20/0x21 with req_valid held high.
        issue(1'b0, 16'h0020, 16'h0000);
        issue(1'b1, 16'h0021, 16'hA5C3);
        issue(1'b0, 16'h0021, 16'h0000);
        issue(1'b1, 16'h0020, 16'h5A3C);
        issue(1'b0, 16'h0020, 16'h0000);

        // Held req_valid with fields scrambled while busy.
        for (int k = 0; k < 4; k++) begin
            issue(k[0], 16'h0050 + 16'(k), 16'h7000 + 16'(k));
            req_addr  = 16'hDEAD;
            req_wdata = 16'hBAD0;
            req_write = ~k[0];
            @(negedge clk);
        end
        issue(1'b0, 16'h0051, 16'h0000);
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("held_rd_0051", resp_rdata, 16'h7001);

        // Reset asserted in the middle of a read.
        issue(1'b0, 16'h0030, 16'h0000);
        req_valid = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_bus_en", bus_en, 0);
        check("mid_rst_bus_data", bus_data, 16'hFFFF);
        check("mid_rst_resp", resp_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", req_ready, 1);
        check("post_rst_rdata", resp_rdata, 16'h0000);
        repeat (4) @(negedge clk);

        // READ_LATENCY=3 instance: 4 enable cycles, response at T+5.
        b_req_valid = 1'b1;
        @(negedge clk);
        b_req_valid = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            if (k > 1) @(negedge clk);
            check("l3_bus_en", b_bus_en, k <= 4);
            check("l3_resp_valid", b_resp_valid, k == 5);
            check("l3_ready", b_req_ready, k >= 6);
            if (k == 5) check("l3_rdata", b_resp_rdata, 16'h1234);
        end
        check("l3_bus_addr", b_bus_addr, 16'h0040);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
